// File: rtl/qc_shift_sequencer.sv
// rtl/qc_shift_sequencer.sv - QC-LDPC base-matrix row sequencer feeding a pipelined circular shifter
// Issues one row's columns, aligns present-tags with shifter latency and XOR-accumulates the result.
module qc_shift_sequencer #(
  parameter int MAXZ     = 81,
  parameter int NUM_COLS = 24,
  parameter int NUM_ROWS = 12,
  localparam int SHIFT_W   = $clog2(MAXZ),
  localparam int SHIFT_LAT = $clog2(MAXZ),
  localparam int COL_W     = $clog2(NUM_COLS),
  localparam int ROW_W     = $clog2(NUM_ROWS)
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ROW_W-1:0]       row_idx_i,
  output logic                   busy_o,
  output logic                   hm_rd_o,
  output logic [ROW_W+COL_W-1:0] hm_addr_o,
  input  logic [SHIFT_W:0]       hm_data_i,
  output logic                   blk_rd_o,
  output logic [COL_W-1:0]       blk_addr_o,
  input  logic [MAXZ-1:0]        blk_data_i,
  output logic [MAXZ-1:0]        sh_data_o,
  output logic [SHIFT_W-1:0]     sh_shift_o,
  input  logic [MAXZ-1:0]        sh_data_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [MAXZ-1:0]        res_data_o,
  output logic                   err_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [SHIFT_W:0] MAXZ_V   = (SHIFT_W + 1)'(MAXZ);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q;
  logic [COL_W-1:0]     col_q;
  logic                 rd_q, rd_last_q;
  logic                 tag_q, tag_last_q;
  logic [SHIFT_LAT-1:0] dly_tag_q, dly_last_q;
  logic                 done_q;
  logic [MAXZ-1:0]      acc_q;
  logic                 err_q;

  logic                 accept;
  logic                 present;
  logic                 in_range;

  assign accept   = (state_q == IDLE) && start_i;
  assign present  = hm_data_i[SHIFT_W];
  assign in_range = {1'b0, hm_data_i[SHIFT_W-1:0]} < MAXZ_V;

  always_ff @(posedge CLK) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   if (col_q == LAST_COL) state_d = DRAIN;
      DRAIN:   if (done_q) state_d = OUTPUT;
      OUTPUT:  if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    hm_rd_o     = (state_q == ISSUE);
    blk_rd_o    = (state_q == ISSUE);
    res_valid_o = (state_q == OUTPUT);
    hm_addr_o   = {row_q, col_q};
    blk_addr_o  = col_q;
    res_data_o  = acc_q;
    err_o       = err_q;
  end

  // Read strobe is registered so the capture stage knows when memory data is real.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      rd_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      sh_data_o  <= '0;
      sh_shift_o <= '0;
      tag_q      <= 1'b0;
      tag_last_q <= 1'b0;
      dly_tag_q  <= '0;
      dly_last_q <= '0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_q      <= hm_rd_o;
      rd_last_q <= hm_rd_o && (col_q == LAST_COL);

      if (accept) begin
        row_q <= row_idx_i;
        col_q <= '0;
      end else if (hm_rd_o) begin
        col_q <= col_q + COL_W'(1);
      end

      tag_q      <= rd_q && present && in_range;
      tag_last_q <= rd_last_q;
      if (rd_q && present && in_range) begin
        sh_data_o  <= blk_data_i;
        sh_shift_o <= hm_data_i[SHIFT_W-1:0];
      end else begin
        sh_data_o  <= '0;
        sh_shift_o <= '0;
      end
      if (rd_q && present && !in_range) err_q <= 1'b1;

      // Tags ride alongside the shifter so each lands with its own rotated block.
      dly_tag_q  <= {dly_tag_q[SHIFT_LAT-2:0], tag_q};
      dly_last_q <= {dly_last_q[SHIFT_LAT-2:0], tag_last_q};
      done_q     <= dly_last_q[SHIFT_LAT-1];

      if (accept)                          acc_q <= '0;
      else if (dly_tag_q[SHIFT_LAT-1])     acc_q <= acc_q ^ sh_data_i;
    end
  end

endmodule

// File: tb/tb_qc_shift_sequencer.sv
// tb/tb_qc_shift_sequencer.sv - directed bench for qc_shift_sequencer
// Models base-matrix/sub-block memories and a 7-stage rotate-right shifter.
module tb_qc_shift_sequencer;

  localparam int MAXZ = 81;
  localparam int NCOL = 24;
  localparam int LAT  = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    row_idx;
  logic          busy;
  logic          hm_rd;
  logic [8:0]    hm_addr;
  logic [7:0]    hm_data;
  logic          blk_rd;
  logic [4:0]    blk_addr;
  logic [80:0]   blk_data;
  logic [80:0]   sh_data_o;
  logic [6:0]    sh_shift_o;
  logic [80:0]   sh_data_i;
  logic          res_valid;
  logic          res_ready;
  logic [80:0]   res_data;
  logic          err;

  logic [7:0]    hm_mem  [0:511];
  logic [80:0]   blk_mem [0:31];
  logic [80:0]   shp     [0:LAT-1];

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [80:0] BIT76 = 81'd1 << 76;
  localparam logic [80:0] D     = 81'h5;
  localparam logic [80:0] D_X   = (81'd1 << 80) | 81'h7;

  always #5 clk = ~clk;

  qc_shift_sequencer dut (
    .CLK(clk), .rst_n(rst_n), .start_i(start), .row_idx_i(row_idx), .busy_o(busy),
    .hm_rd_o(hm_rd), .hm_addr_o(hm_addr), .hm_data_i(hm_data),
    .blk_rd_o(blk_rd), .blk_addr_o(blk_addr), .blk_data_i(blk_data),
    .sh_data_o(sh_data_o), .sh_shift_o(sh_shift_o), .sh_data_i(sh_data_i),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .err_o(err)
  );

  function automatic logic [80:0] rotr(input logic [80:0] x, input logic [6:0] s);
    logic [161:0] w;
    w = {x, x} >> s;
    return w[80:0];
  endfunction

  always @(posedge clk) begin
    if (hm_rd)  hm_data  <= hm_mem[hm_addr];
    if (blk_rd) blk_data <= blk_mem[blk_addr];
    shp[0] <= rotr(sh_data_o, sh_shift_o);
    for (int i = 1; i < LAT; i++) shp[i] <= shp[i-1];
  end
  assign sh_data_i = shp[LAT-1];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_row(input logic [3:0] row, input logic [80:0] exp, input int hold,
                         input string tag);
    int  n;
    int  nrd;
    bit  stable;
    @(negedge clk);
    start   = 1'b1;
    row_idx = row;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_addr0"}, hm_addr, {row, 5'd0});
    n = 0;
    nrd = 0;
    while (!res_valid && n < 100) begin
      if (hm_rd) nrd++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, NCOL + LAT + 3);
    chk({tag, "_nrd"}, nrd, NCOL);
    chk({tag, "_data"}, res_data, exp);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = i[0];
      @(posedge clk); #1;
      if (res_data !== exp || !busy || !res_valid) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, stable, 1'b1);
    @(negedge clk);
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_vld_off"}, res_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int  cnt;
    bit  ok;
    rst_n = 1'b0; start = 1'b0; row_idx = '0; res_ready = 1'b0;
    hm_data = '0; blk_data = '0;
    for (int i = 0; i < LAT; i++) shp[i] = '0;
    for (int i = 0; i < 512; i++) hm_mem[i] = '0;
    for (int i = 0; i < 32; i++) blk_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_hm_rd", hm_rd, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_data", res_data, 81'd0);
    chk("rst_sh", sh_data_o, 81'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single entry: row 0, col 3 shift 5.
    hm_mem[{4'd0, 5'd3}] = 8'h85;
    blk_mem[3] = 81'd1;
    run_row(4'd0, BIT76, 0, "single");

    // Cancellation and rotate-XOR.
    hm_mem[{4'd1, 5'd0}] = 8'h80;
    hm_mem[{4'd1, 5'd1}] = 8'h80;
    blk_mem[0] = D;
    blk_mem[1] = D;
    run_row(4'd1, 81'd0, 0, "cancel");
    hm_mem[{4'd2, 5'd0}] = 8'h80;
    hm_mem[{4'd2, 5'd1}] = 8'h81;
    run_row(4'd2, D_X, 0, "rotxor");
    chk("err_pre", err, 1'b0);

    // Backpressure with ignored start pulses.
    run_row(4'd0, BIT76, 10, "bp");
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_requeue", busy, 1'b0);

    // Out-of-range shift 90 sets err and is excluded.
    hm_mem[{4'd3, 5'd3}] = 8'h85;
    hm_mem[{4'd3, 5'd5}] = 8'h80 | 8'd90;
    blk_mem[5] = 81'hFF;
    run_row(4'd3, BIT76, 0, "errrow");
    chk("err_set", err, 1'b1);
    run_row(4'd4, 81'd0, 0, "absent");
    chk("err_sticky", err, 1'b1);

    // Row index beyond NUM_ROWS passes through.
    hm_mem[{4'd13, 5'd0}] = 8'h80;
    run_row(4'd13, D, 0, "row13");

    // Reset in DRAIN abandons the row.
    @(negedge clk);
    start = 1'b1; row_idx = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_valid", res_valid, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_data", res_data, 81'd0);
    chk("mr_sh", sh_data_o, 81'd0);
    @(negedge clk) rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy) ok = 1'b0;
    end
    chk("mr_quiet", ok, 1'b1);
    run_row(4'd0, BIT76, 0, "mr_after");

    // Back-to-back with start and ready held high.
    @(negedge clk);
    start = 1'b1; row_idx = 4'd0; res_ready = 1'b1;
    cnt = 0;
    ok = 1'b1;
    for (int i = 0; i < 108; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        cnt++;
        if (res_data !== BIT76 || (i % 36) != 34) ok = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    chk("b2b_count", cnt, 3);
    chk("b2b_data", ok, 1'b1);
    @(posedge clk); #1;
    chk("b2b_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
